// File: rtl/xlite_regbank_pkg.sv
// rtl/xlite_regbank_pkg.sv - word indices and field positions for the lite event register bank
package xlite_regbank_pkg;

    localparam int IDX_ID         = 0;
    localparam int IDX_CTRL       = 1;
    localparam int IDX_PEND       = 2;
    localparam int IDX_MASK       = 3;
    localparam int IDX_COUNT_BASE = 4;

    localparam int CTRL_IRQ_EN_BIT = 0;

    // Scratch words follow directly after the per-channel counters.
    function automatic int scratch_base(input int num_ch);
        return IDX_COUNT_BASE + num_ch;
    endfunction

endpackage

// File: rtl/xlite_event_chan.sv
// rtl/xlite_event_chan.sv - one event channel: rising-edge detector and saturating counter
module xlite_event_chan #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ev,
    input  logic             clr,
    output logic             ev_edge,
    output logic [CNT_W-1:0] count
);

    logic ev_q;

    // History resets to 0, so a source already high at reset release counts once.
    assign ev_edge = ev & ~ev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q  <= 1'b0;
            count <= '0;
        end else begin
            ev_q <= ev;
            if (clr) begin
                count <= ev_edge ? CNT_W'(1) : '0;
            end else if (ev_edge && (count != {CNT_W{1'b1}})) begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/xlite_event_regbank.sv
// rtl/xlite_event_regbank.sv - Xillybus-lite register bank with event channels and interrupt
module xlite_event_regbank
    import xlite_regbank_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          NUM_SCRATCH = 4,
    parameter int          CNT_W       = 16,
    parameter int          ADDR_W      = 6,
    parameter logic [31:0] ID_VALUE    = 32'h584C_0002
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    input  logic              user_wren,
    input  logic [3:0]        user_wstrb,
    input  logic              user_rden,
    input  logic [31:0]       user_addr,
    input  logic [31:0]       user_wr_data,
    output logic [31:0]       user_rd_data,
    output logic              user_irq,
    input  logic [NUM_CH-1:0] ev_in
);

    localparam int SCR_BASE = scratch_base(NUM_CH);
    localparam int SCR_N    = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;

    logic [ADDR_W-1:0]            widx;
    logic                         wr_reg;
    logic                         irq_en;
    logic [NUM_CH-1:0]            ev_edge;
    logic [NUM_CH-1:0]            cnt_clr;
    logic [NUM_CH-1:0]            pending;
    logic [NUM_CH-1:0]            pend_clr;
    logic [NUM_CH-1:0]            mask;
    logic [NUM_CH-1:0][CNT_W-1:0] count;
    logic [31:0]                  scratch [SCR_N];
    logic [31:0]                  rd_word;
    logic                         unused_addr;

    assign widx        = user_addr[ADDR_W+1:2];
    assign unused_addr = ^{user_addr[31:ADDR_W+2], user_addr[1:0]};
    // Control-type registers ignore writes that carry no byte enables.
    assign wr_reg      = user_wren && (user_wstrb != 4'b0000);
    assign pend_clr    = (wr_reg && (widx == ADDR_W'(IDX_PEND))) ? user_wr_data[NUM_CH-1:0] : '0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign cnt_clr[i] = wr_reg && (widx == ADDR_W'(IDX_COUNT_BASE + i));

        xlite_event_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk    (bus_clk),
            .rst_n  (bus_rst_n),
            .ev     (ev_in[i]),
            .clr    (cnt_clr[i]),
            .ev_edge(ev_edge[i]),
            .count  (count[i])
        );
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            irq_en   <= 1'b0;
            mask     <= '0;
            pending  <= '0;
            user_irq <= 1'b0;
        end else begin
            if (wr_reg && (widx == ADDR_W'(IDX_CTRL))) begin
                irq_en <= user_wr_data[CTRL_IRQ_EN_BIT];
            end
            if (wr_reg && (widx == ADDR_W'(IDX_MASK))) begin
                mask <= user_wr_data[NUM_CH-1:0];
            end
            // A new edge overrides a coincident write-1-to-clear.
            pending  <= (pending & ~pend_clr) | ev_edge;
            user_irq <= irq_en & (|(pending & mask));
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            for (int j = 0; j < SCR_N; j++) begin
                scratch[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_SCRATCH; j++) begin
                if (user_wren && (widx == ADDR_W'(SCR_BASE + j))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (user_wstrb[b]) begin
                            scratch[j][8*b +: 8] <= user_wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (widx == ADDR_W'(IDX_ID)) begin
            rd_word = ID_VALUE;
        end
        if (widx == ADDR_W'(IDX_CTRL)) begin
            rd_word[CTRL_IRQ_EN_BIT] = irq_en;
        end
        if (widx == ADDR_W'(IDX_PEND)) begin
            rd_word[NUM_CH-1:0] = pending;
        end
        if (widx == ADDR_W'(IDX_MASK)) begin
            rd_word[NUM_CH-1:0] = mask;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (widx == ADDR_W'(IDX_COUNT_BASE + i)) begin
                rd_word = 32'(count[i]);
            end
        end
        for (int j = 0; j < NUM_SCRATCH; j++) begin
            if (widx == ADDR_W'(SCR_BASE + j)) begin
                rd_word = scratch[j];
            end
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            user_rd_data <= '0;
        end else if (user_rden) begin
            user_rd_data <= rd_word;
        end
    end

endmodule

// File: tb/tb_xlite_event_regbank.sv
// tb/tb_xlite_event_regbank.sv - scoreboard bench for the lite event register bank
module tb_xlite_event_regbank;

    logic        bus_clk = 1'b0;
    logic        bus_rst_n = 1'b1;
    logic        user_wren = 1'b0;
    logic [3:0]  user_wstrb = 4'b0;
    logic        user_rden = 1'b0;
    logic [31:0] user_addr = 32'b0;
    logic [31:0] user_wr_data = 32'b0;
    logic [31:0] user_rd_data;
    logic        user_irq;
    logic [3:0]  ev_in = 4'b0;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_fire = 1'b0;

    xlite_event_regbank #(
        .NUM_CH     (4),
        .NUM_SCRATCH(4),
        .CNT_W      (4),
        .ADDR_W     (6),
        .ID_VALUE   (32'h584C_0002)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_rst_n   (bus_rst_n),
        .user_wren   (user_wren),
        .user_wstrb  (user_wstrb),
        .user_rden   (user_rden),
        .user_addr   (user_addr),
        .user_wr_data(user_wr_data),
        .user_rd_data(user_rd_data),
        .user_irq    (user_irq),
        .ev_in       (ev_in)
    );

    always #5 bus_clk = ~bus_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge bus_clk) rd_fire <= user_rden;

    always @(negedge bus_clk) begin
        if (rd_fire) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_read: got %h expected none", user_rd_data);
            end else begin
                check(name_q.pop_front(), user_rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        user_wren    = 1'b1;
        user_addr    = addr;
        user_wr_data = data;
        user_wstrb   = strb;
        @(negedge bus_clk);
        user_wren  = 1'b0;
        user_wstrb = 4'b0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        user_rden = 1'b1;
        user_addr = addr;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge bus_clk);
        user_rden = 1'b0;
    endtask

    task automatic pulse(input int ch);
        ev_in[ch] = 1'b1;
        @(negedge bus_clk);
        ev_in[ch] = 1'b0;
        @(negedge bus_clk);
    endtask

    initial begin
        #1 bus_rst_n = 1'b0;
        repeat (2) @(negedge bus_clk);
        check("reset_irq", {31'b0, user_irq}, 32'h0);
        check("reset_rd_data", user_rd_data, 32'h0);
        bus_rst_n = 1'b1;
        @(negedge bus_clk);

        rd(32'h00, 32'h584C_0002, "id");
        rd(32'h04, 32'h0, "ctrl_reset");
        rd(32'h08, 32'h0, "pend_reset");
        rd(32'h0C, 32'h0, "mask_reset");
        rd(32'h10, 32'h0, "count0_reset");
        rd(32'h20, 32'h0, "scratch0_reset");

        wr(32'h20, 32'hAABB_CCDD, 4'b1111);
        wr(32'h20, 32'h1122_3344, 4'b0101);
        rd(32'h20, 32'hAA22_CC44, "scratch0_bytes");

        // read and write in one cycle: read sees the old contents
        user_wren = 1'b1; user_rden = 1'b1; user_addr = 32'h24;
        user_wr_data = 32'h1234_5678; user_wstrb = 4'b1111;
        exp_q.push_back(32'h0); name_q.push_back("rdwr_old");
        @(negedge bus_clk);
        user_wren = 1'b0; user_rden = 1'b0; user_wstrb = 4'b0;
        rd(32'h24, 32'h1234_5678, "rdwr_new");

        repeat (3) pulse(2);
        rd(32'h18, 32'h3, "count2_three");
        rd(32'h08, 32'h4, "pend_ch2");
        check("irq_masked", {31'b0, user_irq}, 32'h0);
        wr(32'h0C, 32'h4, 4'b1111);
        wr(32'h04, 32'h1, 4'b1111);
        @(negedge bus_clk);
        check("irq_raised", {31'b0, user_irq}, 32'h1);

        wr(32'h0C, 32'h0, 4'b0000);
        rd(32'h0C, 32'h4, "mask_nostrb");

        ev_in[2] = 1'b1;
        wr(32'h08, 32'h4, 4'b1111);
        ev_in[2] = 1'b0;
        rd(32'h08, 32'h4, "pend_set_wins");
        check("irq_held", {31'b0, user_irq}, 32'h1);
        wr(32'h08, 32'h4, 4'b1111);
        check("irq_before_drop", {31'b0, user_irq}, 32'h1);
        @(negedge bus_clk);
        check("irq_dropped", {31'b0, user_irq}, 32'h0);
        rd(32'h08, 32'h0, "pend_cleared");

        wr(32'h0C, 32'hFFFF_FFFF, 4'b1111);
        rd(32'h0C, 32'hF, "mask_upper_zero");

        for (int k = 0; k < 20; k++) pulse(0);
        rd(32'h10, 32'hF, "count0_saturate");
        rd(32'h14, 32'h0, "count1_untouched");
        ev_in[0] = 1'b1;
        wr(32'h10, 32'h0, 4'b0010);
        ev_in[0] = 1'b0;
        rd(32'h10, 32'h1, "count0_clr_edge");
        wr(32'h10, 32'h0, 4'b0001);
        rd(32'h10, 32'h0, "count0_clr");
        rd(32'h3FC, 32'h0, "unmapped");
        rd(32'h20, 32'hAA22_CC44, "scratch0_before_rst");
        check("irq_before_rst", {31'b0, user_irq}, 32'h1);

        @(negedge bus_clk);
        #2 bus_rst_n = 1'b0;
        ev_in[3] = 1'b1;
        #1;
        check("async_rst_rd_data", user_rd_data, 32'h0);
        check("async_rst_irq", {31'b0, user_irq}, 32'h0);
        @(negedge bus_clk);
        bus_rst_n = 1'b1;
        repeat (3) @(negedge bus_clk);
        rd(32'h04, 32'h0, "ctrl_after_rst");
        rd(32'h0C, 32'h0, "mask_after_rst");
        rd(32'h18, 32'h0, "count2_after_rst");
        rd(32'h20, 32'h0, "scratch0_after_rst");
        rd(32'h1C, 32'h1, "count3_high_at_release");
        rd(32'h08, 32'h8, "pend_high_at_release");
        ev_in[3] = 1'b0;

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge bus_clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: got %0d outstanding expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/xlite_event_regbank.md
Name: xlite_event_regbank

Overview:
- Parametrised register bank on the Xillybus-lite user interface (user_* pins); the next generation of the fixed user-side register logic.
- Provides an ID register, a control register and scratch registers with byte strobes.
- Adds NUM_CH event channels: rising-edge detection, saturating counters, write-1-to-clear pending bits and a mask.
- Drives the lite user_irq line.
- Sits in the PL between the Xillybus-lite core and user logic, in the bus_clk domain.

Parameters:
- NUM_CH, 4: event channels, 1..32.
- NUM_SCRATCH, 4: 32-bit scratch registers, 0..16.
- CNT_W, 16: event counter width, 1..32.
- ADDR_W, 6: word-address bits decoded. Requires 4+NUM_CH+NUM_SCRATCH <= 2**ADDR_W.
- ID_VALUE, 32'h584C_0002: constant returned by the ID register.

Ports:
- bus_clk, input, 1: sole clock.
- bus_rst_n, input, 1: asynchronous active-low reset.
- user_wren, input, 1: write strobe, single cycle.
- user_wstrb, input, 4: byte enables for the write.
- user_rden, input, 1: read strobe, single cycle.
- user_addr, input, 32: byte address. Bits [ADDR_W+1:2] are decoded; all others are ignored.
- user_wr_data, input, 32: write data.
- user_rd_data, output, 32: read data, valid the cycle after user_rden.
- user_irq, output, 1: interrupt request to the lite core.
- ev_in, input, NUM_CH: event sources, synchronous to bus_clk.

Behaviour:

Address map (word index):
- 0: ID. RO, returns ID_VALUE.
- 1: CTRL. RW. bit0 = irq_en; bits 31:1 read 0.
- 2: PENDING. Bits [NUM_CH-1:0]. Write 1 clears, write 0 no effect.
- 3: MASK. RW, bits [NUM_CH-1:0].
- 4..4+NUM_CH-1: COUNT[i], zero-extended to 32 bits. Any write with any wstrb bit set clears the counter.
- 4+NUM_CH .. +NUM_SCRATCH-1: SCRATCH[j]. RW, byte-granular per user_wstrb.
- Unmapped: reads return 0, writes ignored.
- Bits above NUM_CH in PENDING and MASK read 0 and ignore writes.
- Register writes to CTRL, PENDING, MASK and COUNT apply only if user_wstrb != 0. Byte lanes are honoured for scratch only.

Reset (asynchronous assert, synchronous deassert by the caller):
- user_rd_data=0, user_irq=0.
- CTRL, PENDING, MASK, COUNT and SCRATCH all 0.
- ev_in history register = 0.

Read path:
- user_rd_data is registered, 1-cycle latency.
- It updates only on a cycle with user_rden=1 and holds otherwise.
- Reads have no side effects.
- user_rden and user_wren in the same cycle: both are performed. Read returns the pre-write value.

Edge detect:
- ev_q <= ev_in each cycle.
- edge[i] = ev_in[i] & ~ev_q[i].
- A level held high produces exactly one edge.
- ev_in already high at reset release produces an edge on the first clock, because history resets to 0.

Counters:
- On edge[i], COUNT[i] increments, saturating at 2**CNT_W-1. No wrap.
- Clear-write and edge in the same cycle: COUNT[i] becomes 1.

Pending:
- PENDING[i] is set on edge[i], independent of MASK.
- W1C and edge in the same cycle: set wins, bit stays 1.

Interrupt:
- user_irq is registered: irq_en & |(PENDING & MASK), one cycle after the state changes.
- The lite core is edge-sensitive. Software clears pending, and a further unmasked event produces a new rising edge.
- Unmasking an already-pending bit raises user_irq on the following cycle.

Sizing rule: 120-300 lines of RTL.

Decomposition:
- Package xlite_regbank_pkg holds:
  - register word-index constants (IDX_ID=0, IDX_CTRL=1, IDX_PEND=2, IDX_MASK=3, IDX_COUNT_BASE=4);
  - a function for the scratch base, 4+NUM_CH;
  - the CTRL bit-position constant.
- One sub-module, xlite_event_chan: one channel's edge detector and saturating counter, with ports clk, rst_n, ev, clr, edge, count. Instantiate it NUM_CH times in a generate loop.
- PENDING, MASK, CTRL, scratch and the read mux stay in the top module.

Test Plan:
- Reset, then read word 0 -> user_rd_data=32'h584C_0002 one cycle after rden. user_irq=0, all other registers read 0.
- Write SCRATCH[0]=32'hAABBCCDD with wstrb=4'b1111, then write 32'h11223344 with wstrb=4'b0101 -> readback 32'hAA22CC44.
- Pulse ev_in[2] three times -> COUNT[2]=3 and PENDING=32'h4. With MASK=0: user_irq stays 0. Write MASK=4 and CTRL=1 -> user_irq=1 within 2 cycles.
- Write PENDING=32'h4 in the same cycle as a new ev_in[2] edge -> PENDING stays 32'h4, user_irq stays 1. Then W1C alone -> PENDING=0, user_irq=0 one cycle later.
- CNT_W=4, 20 edges on ch0 -> COUNT[0]=15, no wrap. Clear-write coincident with an edge -> COUNT[0]=1.
- Assert bus_rst_n low mid-sequence with registers non-zero -> all outputs and registers are 0 immediately, without a clock edge. Read at address 0x3FC (unmapped) -> 0.
